// File: rtl/softmax_axis_sink.sv
// softmax_axis_sink: AXI4-Stream result collector for the softmax core.
// Captures one tlast-terminated frame into a small buffer, reports length,
// beat count and overflow, offers a registered read port, optionally gates
// ready with a rotating mask, and flags source stability violations.
module softmax_axis_sink #(
  parameter int data_size = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4
) (
  input  logic                     axi_clock_i,
  input  logic                     axi_reset_i,
  input  logic                     s_axis_valid_i,
  input  logic [2*data_size-1:0]   s_axis_data_i,
  input  logic                     s_axis_last_i,
  output logic                     s_axis_ready_o,
  input  logic                     throttle_en_i,
  input  logic [7:0]               throttle_mask_i,
  input  logic                     frame_ack_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [2*data_size-1:0]   rd_data_o,
  output logic                     frame_done_o,
  output logic [ADDR_W:0]          frame_len_o,
  output logic [7:0]               frame_beats_o,
  output logic                     overflow_o,
  output logic                     protocol_err_o
);

  localparam int WORD_W = 2 * data_size;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [0:0] S_RECV = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  logic [0:0]        state;
  logic [7:0]        mask_q;
  logic [ADDR_W:0]   wr_ptr;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              stall_p0;
  logic [WORD_W-1:0] data_p0;
  logic              last_p0;

  logic beat;
  logic room;

  // An all-zero pattern would never raise ready, so it is promoted to all-ones.
  function automatic logic [7:0] mask_load(input logic [7:0] m);
    return (m == 8'h00) ? 8'hFF : m;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Ready depends only on registered state and the static throttle enable.
  assign s_axis_ready_o = (state == S_RECV) && (!throttle_en_i || mask_q[0]);
  assign beat           = s_axis_valid_i && s_axis_ready_o;
  assign room           = (wr_ptr < DEPTH_C);

  // Frame reception control: state, write pointer, counters, throttle mask.
  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      state         <= S_RECV;
      mask_q        <= mask_load(throttle_mask_i);
      wr_ptr        <= '0;
      frame_len_o   <= '0;
      frame_beats_o <= '0;
      overflow_o    <= 1'b0;
      frame_done_o  <= 1'b0;
    end else begin
      mask_q <= {mask_q[0], mask_q[7:1]};
      case (state)
        S_RECV: begin
          if (beat) begin
            if (room) wr_ptr <= wr_ptr + 1'b1;
            else      overflow_o <= 1'b1;
            frame_beats_o <= sat_inc8(frame_beats_o);
            if (s_axis_last_i) begin
              frame_len_o  <= room ? (wr_ptr + 1'b1) : DEPTH_C;
              frame_done_o <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (frame_ack_i) begin
            state         <= S_RECV;
            wr_ptr        <= '0;
            frame_len_o   <= '0;
            frame_beats_o <= '0;
            overflow_o    <= 1'b0;
            frame_done_o  <= 1'b0;
            mask_q        <= mask_load(throttle_mask_i);
          end
        end
        default: state <= S_RECV;
      endcase
    end
  end

  // Buffer write; beats past DEPTH are dropped.
  always_ff @(posedge axi_clock_i) begin
    if (beat && room) mem[wr_ptr[ADDR_W-1:0]] <= s_axis_data_i;
  end

  // Registered random-access read, active in every state.
  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) rd_data_o <= '0;
    else             rd_data_o <= mem[rd_addr_i];
  end

  // Stage p0: remember the previous cycle's stall and beat contents.
  always_ff @(posedge axi_clock_i) begin
    data_p0 <= s_axis_data_i;
    last_p0 <= s_axis_last_i;
  end

  // Sticky stability checker: a stalled beat must stay valid and unchanged.
  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      stall_p0       <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      stall_p0 <= s_axis_valid_i && !s_axis_ready_o;
      if (stall_p0 && (!s_axis_valid_i || (s_axis_data_i != data_p0) ||
                       (s_axis_last_i != last_p0)))
        protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_softmax_axis_sink.sv
// Testbench for softmax_axis_sink: randomized frames checked against a
// queue-based frame model and a cycle-indexed throttle pattern.
module tb_softmax_axis_sink;

  logic        clk = 1'b0;
  logic        axi_reset_i;
  logic        s_axis_valid_i;
  logic [31:0] s_axis_data_i;
  logic        s_axis_last_i;
  logic        s_axis_ready_o;
  logic        throttle_en_i;
  logic [7:0]  throttle_mask_i;
  logic        frame_ack_i;
  logic [3:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic        frame_done_o;
  logic [4:0]  frame_len_o;
  logic [7:0]  frame_beats_o;
  logic        overflow_o;
  logic        protocol_err_o;

  always #5 clk = ~clk;

  softmax_axis_sink #(.data_size(16), .DEPTH(16), .ADDR_W(4)) dut (
    .axi_clock_i    (clk),
    .axi_reset_i    (axi_reset_i),
    .s_axis_valid_i (s_axis_valid_i),
    .s_axis_data_i  (s_axis_data_i),
    .s_axis_last_i  (s_axis_last_i),
    .s_axis_ready_o (s_axis_ready_o),
    .throttle_en_i  (throttle_en_i),
    .throttle_mask_i(throttle_mask_i),
    .frame_ack_i    (frame_ack_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .frame_done_o   (frame_done_o),
    .frame_len_o    (frame_len_o),
    .frame_beats_o  (frame_beats_o),
    .overflow_o     (overflow_o),
    .protocol_err_o (protocol_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words that fit, counts, flags, and throttle pattern phase.
  logic [31:0] stored[$];
  logic [31:0] tx[$];
  int          m_len, m_beats;
  bit          m_ovf, m_done, m_err;
  logic [7:0]  m_mask;
  int          k;

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic model_clear();
    stored.delete();
    m_len = 0; m_beats = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic do_reset(input logic [7:0] mask, input logic en);
    axi_reset_i = 1'b1; throttle_mask_i = mask; throttle_en_i = en;
    s_axis_valid_i = 1'b0; s_axis_last_i = 1'b0; s_axis_data_i = '0;
    frame_ack_i = 1'b0; rd_addr_i = '0;
    step(); step();
    axi_reset_i = 1'b0;
    k = 0;
    m_mask = (mask == 8'h00) ? 8'hFF : mask;
    model_clear();
    m_err = 0;
  endtask

  task automatic do_ack();
    frame_ack_i = 1'b1;
    step();
    frame_ack_i = 1'b0;
    k = 0;
    m_mask = (throttle_mask_i == 8'h00) ? 8'hFF : throttle_mask_i;
    model_clear();
  endtask

  // Drives tx[] beat by beat, holding each beat until accepted.
  task automatic send_frame(input bit with_last);
    for (int i = 0; i < tx.size(); i++) begin
      bit   acc;
      int   cnt;
      logic er;
      s_axis_valid_i = 1'b1;
      s_axis_data_i  = tx[i];
      s_axis_last_i  = with_last && (i == tx.size() - 1);
      acc = 0; cnt = 0;
      while (!acc && cnt < 64) begin
        er = !m_done && (!throttle_en_i || m_mask[k % 8]);
        checks++;
        if (s_axis_ready_o !== er) begin
          errors++;
          $display("FAIL ready beat %0d cyc %0d: got %b exp %b", i, k, s_axis_ready_o, er);
        end
        checks++;
        if (overflow_o !== m_ovf || frame_beats_o !== 8'(m_beats) || frame_done_o !== m_done) begin
          errors++;
          $display("FAIL progress beat %0d: ovf %b/%b beats %0d/%0d done %b/%b", i,
                   overflow_o, m_ovf, frame_beats_o, m_beats, frame_done_o, m_done);
        end
        acc = s_axis_ready_o;
        step();
        cnt++;
      end
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout beat %0d: got no handshake exp handshake", i);
        break;
      end
      if (stored.size() < 16) stored.push_back(tx[i]);
      else m_ovf = 1;
      if (m_beats < 255) m_beats++;
      if (s_axis_last_i) begin
        m_len = stored.size();
        m_done = 1;
      end
    end
    s_axis_valid_i = 1'b0;
    s_axis_last_i  = 1'b0;
    if (with_last) begin
      checks++;
      if (frame_done_o !== 1'b1 || s_axis_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL done_timing: done %b ready %b exp done 1 ready 0", frame_done_o, s_axis_ready_o);
      end
    end
  endtask

  task automatic fill_random(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back($urandom);
  endtask

  task automatic test_reset();
    do_reset(8'h00, 1'b0);
    checks++;
    if (s_axis_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", s_axis_ready_o); end
    checks++;
    if (rd_data_o !== 32'h0) begin errors++; $display("FAIL rst_rd_data got %h exp 0", rd_data_o); end
    checks++;
    if (frame_done_o !== 1'b0 || frame_len_o !== 5'd0 || frame_beats_o !== 8'd0) begin
      errors++; $display("FAIL rst_frame got done %b len %0d beats %0d exp 0 0 0", frame_done_o, frame_len_o, frame_beats_o);
    end
    checks++;
    if (overflow_o !== 1'b0 || protocol_err_o !== 1'b0) begin
      errors++; $display("FAIL rst_flags got ovf %b err %b exp 0 0", overflow_o, protocol_err_o);
    end
  endtask

  task automatic test_basic();
    do_reset(8'h00, 1'b0);
    tx = '{32'h3E0F5C29, 32'h3D23D70A, 32'h3F3AE148, 32'h3C23D70A, 32'h3E4CCCCD};
    send_frame(1);
    checks++;
    if (frame_len_o !== 5'd5 || frame_beats_o !== 8'd5 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL basic_status got len %0d beats %0d ovf %b exp 5 5 0", frame_len_o, frame_beats_o, overflow_o);
    end
    for (int a = 0; a < m_len; a++) begin
      rd_addr_i = 4'(a); step(); checks++;
      if (rd_data_o !== stored[a]) begin errors++; $display("FAIL basic_rd[%0d] got %h exp %h", a, rd_data_o, stored[a]); end
    end
  endtask

  task automatic test_throttle();
    do_reset(8'b0101_0101, 1'b1);
    fill_random(8);
    send_frame(1);
    checks++;
    if (frame_len_o !== 5'(m_len) || protocol_err_o !== 1'b0) begin
      errors++; $display("FAIL thr_status got len %0d err %b exp %0d 0", frame_len_o, protocol_err_o, m_len);
    end
    for (int a = 0; a < m_len; a++) begin
      rd_addr_i = 4'(a); step(); checks++;
      if (rd_data_o !== stored[a]) begin errors++; $display("FAIL thr_rd[%0d] got %h exp %h", a, rd_data_o, stored[a]); end
    end
  endtask

  task automatic test_zero_mask();
    do_reset(8'h00, 1'b1);
    fill_random(8);
    send_frame(1);
    checks++;
    if (frame_len_o !== 5'd8) begin errors++; $display("FAIL zmask_len got %0d exp 8", frame_len_o); end
  endtask

  task automatic test_overflow();
    do_reset(8'h00, 1'b0);
    fill_random(20);
    send_frame(1);
    checks++;
    if (frame_len_o !== 5'd16 || frame_beats_o !== 8'd20 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_status got len %0d beats %0d ovf %b exp 16 20 1", frame_len_o, frame_beats_o, overflow_o);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr_i = 4'(a); step(); checks++;
      if (rd_data_o !== tx[a]) begin errors++; $display("FAIL ovf_rd[%0d] got %h exp %h", a, rd_data_o, tx[a]); end
    end
  endtask

  task automatic test_saturation();
    do_reset(8'h00, 1'b0);
    fill_random(260);
    send_frame(1);
    checks++;
    if (frame_beats_o !== 8'd255 || frame_len_o !== 5'd16) begin
      errors++; $display("FAIL sat_beats got %0d len %0d exp 255 16", frame_beats_o, frame_len_o);
    end
  endtask

  task automatic test_protocol();
    do_reset(8'b0000_0010, 1'b1);
    s_axis_valid_i = 1'b1; s_axis_data_i = $urandom; s_axis_last_i = 1'b0;
    step();
    s_axis_valid_i = 1'b0;
    checks++;
    if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL perr_early got %b exp 0", protocol_err_o); end
    step();
    m_err = 1;
    checks++;
    if (protocol_err_o !== m_err) begin errors++; $display("FAIL perr_set got %b exp %b", protocol_err_o, m_err); end
    fill_random(1);
    send_frame(1);
    do_ack();
    step();
    checks++;
    if (protocol_err_o !== m_err) begin errors++; $display("FAIL perr_sticky got %b exp %b", protocol_err_o, m_err); end
    do_reset(8'h00, 1'b0);
    checks++;
    if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL perr_reset got %b exp 0", protocol_err_o); end
  endtask

  task automatic test_done_hold();
    logic [31:0] hold_w;
    int          len0, beats0;
    do_reset(8'h00, 1'b0);
    fill_random(3);
    send_frame(1);
    len0 = m_len; beats0 = m_beats;
    hold_w = $urandom;
    s_axis_valid_i = 1'b1; s_axis_data_i = hold_w; s_axis_last_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(); checks++;
      if (s_axis_ready_o !== 1'b0) begin errors++; $display("FAIL hold_ready cyc %0d got %b exp 0", c, s_axis_ready_o); end
    end
    checks++;
    if (frame_len_o !== 5'(len0) || frame_beats_o !== 8'(beats0)) begin
      errors++; $display("FAIL hold_frozen got len %0d beats %0d exp %0d %0d", frame_len_o, frame_beats_o, len0, beats0);
    end
    do_ack();
    checks++;
    if (s_axis_ready_o !== 1'b1 || frame_len_o !== 5'd0 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL ack_rearm got ready %b len %0d done %b exp 1 0 0", s_axis_ready_o, frame_len_o, frame_done_o);
    end
    tx = '{hold_w, 32'($urandom), 32'($urandom)};
    send_frame(1);
    rd_addr_i = 4'd0; step(); checks++;
    if (rd_data_o !== hold_w || frame_len_o !== 5'd3) begin
      errors++; $display("FAIL ack_next got rd0 %h len %0d exp %h 3", rd_data_o, frame_len_o, hold_w);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(8'h00, 1'b0);
    fill_random(3);
    send_frame(0);
    do_reset(8'h00, 1'b0);
    checks++;
    if (s_axis_ready_o !== 1'b1 || rd_data_o !== 32'h0 || frame_done_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst got ready %b rd %h done %b exp 1 0 0", s_axis_ready_o, rd_data_o, frame_done_o);
    end
    checks++;
    if (frame_len_o !== 5'd0 || frame_beats_o !== 8'd0 || overflow_o !== 1'b0 || protocol_err_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_cnt got len %0d beats %0d ovf %b err %b exp 0 0 0 0",
                         frame_len_o, frame_beats_o, overflow_o, protocol_err_o);
    end
    fill_random(2);
    send_frame(1);
    checks++;
    if (frame_len_o !== 5'd2 || frame_beats_o !== 8'd2) begin
      errors++; $display("FAIL mid_rst_next got len %0d beats %0d exp 2 2", frame_len_o, frame_beats_o);
    end
    for (int a = 0; a < m_len; a++) begin
      rd_addr_i = 4'(a); step(); checks++;
      if (rd_data_o !== stored[a]) begin errors++; $display("FAIL mid_rd[%0d] got %h exp %h", a, rd_data_o, stored[a]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(8'($urandom), 1'b1);
    for (int f = 0; f < 4; f++) begin
      throttle_mask_i = 8'($urandom);
      fill_random(int'($urandom_range(1, 20)));
      send_frame(1);
      checks++;
      if (frame_len_o !== 5'(m_len) || overflow_o !== m_ovf || frame_beats_o !== 8'(m_beats)) begin
        errors++; $display("FAIL b2b_status f%0d got len %0d ovf %b beats %0d exp %0d %b %0d",
                           f, frame_len_o, overflow_o, frame_beats_o, m_len, m_ovf, m_beats);
      end
      for (int a = 0; a < m_len; a++) begin
        rd_addr_i = 4'(a); step(); checks++;
        if (rd_data_o !== stored[a]) begin errors++; $display("FAIL b2b_rd f%0d[%0d] got %h exp %h", f, a, rd_data_o, stored[a]); end
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throttle();
    test_zero_mask();
    test_overflow();
    test_saturation();
    test_protocol();
    test_done_hold();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_axis_sink.md
# softmax_axis_sink

AXI4-Stream result collector for the softmax core's master output port. Accepts 32-bit float results beat by beat and stores one frame (terminated by tlast) in an internal buffer. Exposes the frame length, an overflow flag and a registered random-access read port. Programmable ready throttling exercises the core's backpressure path; a built-in checker flags AXI-Stream stability violations.

## Interface
- data_size, 16, half of stream word width; words are 2*data_size bits
- DEPTH, 16, frame buffer depth in words (power of two)
- ADDR_W, 4, log2(DEPTH)

- axi_clock_i  in  1  clock, all logic on rising edge
- axi_reset_i  in  1  synchronous, active-high reset
- s_axis_valid_i  in  1  source (softmax m_axis_valid_o) has a beat
- s_axis_data_i  in  2*data_size  beat data
- s_axis_last_i  in  1  final beat of frame
- s_axis_ready_o  out  1  sink accepts a beat this cycle
- throttle_en_i  in  1  enable ready gating by rotating mask
- throttle_mask_i  in  8  ready pattern; bit0 applies first
- frame_ack_i  in  1  host releases buffer, rearms reception
- rd_addr_i  in  ADDR_W  buffer read address
- rd_data_o  out  2*data_size  registered buffer word
- frame_done_o  out  1  complete frame held
- frame_len_o  out  ADDR_W+1  words stored (0..DEPTH)
- frame_beats_o  out  8  beats received, saturates at 255
- overflow_o  out  1  frame exceeded DEPTH; extra beats dropped
- protocol_err_o  out  1  sticky AXI-Stream stability violation

## Operation
- FSM states: S_RECV, S_DONE. Reset -> S_RECV.
- Handshake: beat accepted at rising edge when s_axis_valid_i && s_axis_ready_o.
- s_axis_ready_o = (state==S_RECV) && (!throttle_en_i || mask_q[0]); combinational from registers only, never from s_axis_valid_i.
- mask_q: 8-bit register, rotates right by 1 every cycle; loaded from throttle_mask_i on reset and on accepted frame_ack_i. Loaded value 8'h00 is replaced by 8'hFF (no deadlock).
- S_RECV, accepted beat: if wr_ptr < DEPTH, mem[wr_ptr] <= data, wr_ptr++; else overflow_o <= 1, data discarded. frame_beats_o increments (saturating 255).
- Accepted beat with s_axis_last_i: frame_len_o <= stored count including this beat (capped at DEPTH), frame_done_o <= 1, state -> S_DONE.
- S_DONE: ready low; buffer, frame_len_o, frame_beats_o, overflow_o frozen. frame_ack_i -> S_RECV, wr_ptr, frame_beats_o, frame_len_o, overflow_o, frame_done_o cleared, mask_q reloaded.
- frame_ack_i in S_RECV ignored.
- Read port: rd_data_o <= mem[rd_addr_i] every cycle in any state; addresses >= frame_len_o return stale contents (not cleared).
- Checker: while prev cycle had valid=1 and ready=0, current cycle valid=0 or data/last changed -> protocol_err_o <= 1. Sticky until reset only.

## Timing
- Reset values: s_axis_ready_o 1 when throttle off (S_RECV), rd_data_o 0, frame_done_o 0, frame_len_o 0, frame_beats_o 0, overflow_o 0, protocol_err_o 0; memory contents not reset.
- Throughput: one beat/cycle with throttle off.
- frame_done_o rises the cycle after the last-beat handshake; ready low that same cycle.
- frame_ack_i sampled at edge t -> ready may be high from cycle t+1.
- rd_data_o latency 1 cycle from rd_addr_i.
- Overflow: overflow_o rises the cycle after the first dropped beat.
- Single-beat frame (valid+last on first beat): frame_len_o=1.
- Reset mid-frame: partial frame discarded, all outputs to reset values; reset beats frame_ack_i.

## Test plan
- 5-beat frame 0x3E0F5C29,0x3D23D70A,0x3F3AE148,0x3C23D70A,0x3E4CCCCD, last on beat 5, throttle off -> frame_done_o=1 one cycle after beat 5, frame_len_o=5, frame_beats_o=5, rd_addr 0..4 return the words at 1-cycle latency, overflow_o=0.
- Throttle mask 8'b0101_0101, 8-beat frame, source holds stable -> ready alternates 1,0; all 8 words stored in order, protocol_err_o=0.
- 20-beat frame, DEPTH=16 -> frame_len_o=16, frame_beats_o=20, overflow_o=1, mem[15] = beat 16.
- Source drops valid while ready low (mask 8'b0000_0010) -> protocol_err_o=1 next cycle, stays 1 after frame_ack_i, cleared only by reset.
- In S_DONE, source asserts valid for 10 cycles -> ready stays 0, no store; frame_ack_i -> next cycle ready=1, frame_len_o=0, next frame captured from address 0.
- Reset asserted after beat 3 of 5 -> all outputs at reset values; new 2-beat frame gives frame_len_o=2.
